// File: rtl/axis_pulse_sequencer.sv
// Plays a pulse program from a BRAM read port onto TX (128b) and RX (64b) AXI-Stream
// event streams, repeating the program for a configured number of passes.
module axis_pulse_sequencer #(
    parameter int BRAM_ADDR_WIDTH = 10,
    parameter int BRAM_DATA_WIDTH = 128
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       run,
    input  logic [BRAM_ADDR_WIDTH-1:0] cfg_length,
    input  logic [31:0]                cfg_repeats,
    output logic [31:0]                sts_pass,
    output logic                       busy,
    output logic                       bram_porta_clk,
    output logic                       bram_porta_rst,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_porta_addr,
    input  logic [BRAM_DATA_WIDTH-1:0] bram_porta_rddata,
    output logic [127:0]               m_axis_tx_evts_tdata,
    output logic                       m_axis_tx_evts_tvalid,
    input  logic                       m_axis_tx_evts_tready,
    output logic [63:0]                m_axis_rx_evts_tdata,
    output logic                       m_axis_rx_evts_tvalid,
    input  logic                       m_axis_rx_evts_tready
);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_LATCH, S_SEND, S_NEXT} state_t;

    localparam logic [1:0] T_TX  = 2'b00;
    localparam logic [1:0] T_RX  = 2'b01;
    localparam logic [1:0] T_NOP = 2'b10;

    state_t                     state, state_d;
    logic [BRAM_ADDR_WIDTH-1:0] addr, len_q, addr_inc;
    logic [31:0]                rep_q, pass_inc;
    logic [123:0]               word_reg;
    logic [1:0]                 word_type;
    logic                       start, end_pass, all_done, handshake;
    logic                       unused_bits;

    assign bram_porta_clk  = aclk;
    assign bram_porta_rst  = ~aresetn;
    assign bram_porta_addr = addr;
    assign busy            = (state != S_IDLE);

    assign m_axis_tx_evts_tdata = {4'b0000, word_reg};
    assign m_axis_rx_evts_tdata = word_reg[63:0];

    assign word_type   = bram_porta_rddata[127:126];
    assign unused_bits = ^bram_porta_rddata[125:124];
    assign addr_inc    = addr + 1'b1;
    assign pass_inc    = sts_pass + 32'd1;
    assign all_done    = (rep_q != 32'd0) && (pass_inc == rep_q);
    assign handshake   = (m_axis_tx_evts_tvalid & m_axis_tx_evts_tready) |
                         (m_axis_rx_evts_tvalid & m_axis_rx_evts_tready);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= S_IDLE;
        else          state <= state_d;
    end

    always_comb begin
        state_d  = state;
        start    = 1'b0;
        end_pass = 1'b0;
        case (state)
            S_IDLE: begin
                if (run && cfg_length != '0) begin
                    start   = 1'b1;
                    state_d = S_READ;
                end
            end
            S_READ:  state_d = S_LATCH;
            S_LATCH: begin
                if (word_type == T_TX || word_type == T_RX) state_d = S_SEND;
                else if (word_type == T_NOP)                 state_d = S_NEXT;
                else                                         end_pass = 1'b1;
            end
            S_SEND: if (handshake) state_d = S_NEXT;
            S_NEXT: begin
                if (addr_inc == len_q) end_pass = 1'b1;
                else                   state_d  = run ? S_READ : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A finished pass overrides the per-state target; the last pass always parks.
        if (end_pass) state_d = (all_done || !run) ? S_IDLE : S_READ;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            addr                  <= '0;
            len_q                 <= '0;
            rep_q                 <= '0;
            sts_pass              <= '0;
            word_reg              <= '0;
            m_axis_tx_evts_tvalid <= 1'b0;
            m_axis_rx_evts_tvalid <= 1'b0;
        end else begin
            if (start) begin
                addr     <= '0;
                len_q    <= cfg_length;
                rep_q    <= cfg_repeats;
                sts_pass <= '0;
            end
            if (state == S_LATCH) begin
                word_reg              <= bram_porta_rddata[123:0];
                m_axis_tx_evts_tvalid <= (word_type == T_TX);
                m_axis_rx_evts_tvalid <= (word_type == T_RX);
            end
            if (state == S_SEND && handshake) begin
                m_axis_tx_evts_tvalid <= 1'b0;
                m_axis_rx_evts_tvalid <= 1'b0;
            end
            if (state == S_NEXT) addr <= addr_inc;
            if (end_pass) begin
                sts_pass <= pass_inc;
                addr     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_axis_pulse_sequencer.sv
// Directed bench for axis_pulse_sequencer: a registered BRAM model, a handshake monitor,
// and hand-computed expectations checked with immediate assertions.
module tb_axis_pulse_sequencer;

    logic         aclk, aresetn, run;
    logic [9:0]   cfg_length;
    logic [31:0]  cfg_repeats, sts_pass;
    logic         busy, bram_porta_clk, bram_porta_rst;
    logic [9:0]   bram_porta_addr;
    logic [127:0] bram_porta_rddata;
    logic [127:0] tx_tdata;
    logic         tx_tvalid, tx_tready;
    logic [63:0]  rx_tdata;
    logic         rx_tvalid, rx_tready;

    logic [127:0] mem [0:1023];
    int           ev_kind[$];
    logic [127:0] ev_data[$];
    int           both_cnt = 0;
    int           n_checks = 0;
    int           n_fail   = 0;

    axis_pulse_sequencer #(.BRAM_ADDR_WIDTH(10), .BRAM_DATA_WIDTH(128)) dut (
        .aclk(aclk), .aresetn(aresetn), .run(run),
        .cfg_length(cfg_length), .cfg_repeats(cfg_repeats),
        .sts_pass(sts_pass), .busy(busy),
        .bram_porta_clk(bram_porta_clk), .bram_porta_rst(bram_porta_rst),
        .bram_porta_addr(bram_porta_addr), .bram_porta_rddata(bram_porta_rddata),
        .m_axis_tx_evts_tdata(tx_tdata), .m_axis_tx_evts_tvalid(tx_tvalid),
        .m_axis_tx_evts_tready(tx_tready),
        .m_axis_rx_evts_tdata(rx_tdata), .m_axis_rx_evts_tvalid(rx_tvalid),
        .m_axis_rx_evts_tready(rx_tready)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    always @(posedge aclk) bram_porta_rddata <= mem[bram_porta_addr];

    always @(posedge aclk) begin
        if (tx_tvalid && tx_tready) begin ev_kind.push_back(0); ev_data.push_back(tx_tdata); end
        if (rx_tvalid && rx_tready) begin ev_kind.push_back(1); ev_data.push_back({64'h0, rx_tdata}); end
        if (tx_tvalid && rx_tvalid) both_cnt++;
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input int bound, input string tag);
        int n = 0;
        while (busy && n < bound) begin tick(); n++; end
        chk(tag, busy, 1'b0);
    endtask

    function automatic logic [127:0] txw(input logic [1:0] pad, input logic [83:0] hi, input logic [39:0] lo);
        return {2'b00, pad, hi, lo};
    endfunction

    localparam logic [127:0] NOP  = {2'b10, 126'h0};
    localparam logic [127:0] HALT = {2'b11, 126'h0};

    initial begin
        logic [127:0] w_a, w_b, w_rx, w_c, w_f;
        for (int i = 0; i < 1024; i++) mem[i] = NOP;
        aresetn = 1'b0; run = 1'b0; cfg_length = '0; cfg_repeats = '0;
        tx_tready = 1'b1; rx_tready = 1'b1;
        tick(); tick();

        // reset state
        chk("rst_busy", busy, 1'b0);
        chk("rst_pass", sts_pass, 32'd0);
        chk("rst_txv", tx_tvalid, 1'b0);
        chk("rst_rxv", rx_tvalid, 1'b0);
        chk("rst_txd", tx_tdata, 128'd0);
        chk("rst_bram_rst", bram_porta_rst, 1'b1);
        aresetn = 1'b1;
        tick();
        chk("bram_rst_rel", bram_porta_rst, 1'b0);

        // TX single beat, latency 3
        w_a = txw(2'b00, 84'hA5, 40'd100);
        mem[0] = w_a;
        cfg_length = 10'd1; cfg_repeats = 32'd1; run = 1'b1;
        tick();
        chk("t1_c1_txv", tx_tvalid, 1'b0);
        chk("t1_c1_busy", busy, 1'b1);
        tick();
        chk("t1_c2_txv", tx_tvalid, 1'b0);
        tick();
        chk("t1_c3_txv", tx_tvalid, 1'b1);
        chk("t1_c3_txd", tx_tdata, {4'h0, 84'hA5, 40'd100});
        run = 1'b0;
        tick();
        chk("t1_c4_txv", tx_tvalid, 1'b0);
        tick();
        chk("t1_c5_busy", busy, 1'b0);
        chk("t1_pass", sts_pass, 32'd1);
        chk("t1_beats", ev_kind.size(), 1);
        chk("t1_rx_none", (ev_kind.size() > 0) ? ev_kind[0] : -1, 0);

        // mixed routing TX, RX, NOP, TX (TX pad bits must be stripped)
        ev_kind.delete(); ev_data.delete();
        w_b  = txw(2'b11, 84'h123456789, 40'hFF_0000_0001);
        w_rx = {2'b01, 62'h2AAA_BBBB_CCCC_DDDD, 64'h1_0000_0005};
        mem[0] = w_a; mem[1] = w_rx; mem[2] = NOP; mem[3] = w_b;
        cfg_length = 10'd4; cfg_repeats = 32'd1; run = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        run = 1'b0;
        wait_idle(20, "t2_idle");
        chk("t2_nbeats", ev_kind.size(), 3);
        if (ev_kind.size() == 3) begin
            chk("t2_k0", ev_kind[0], 0);
            chk("t2_k1", ev_kind[1], 1);
            chk("t2_k2", ev_kind[2], 0);
            chk("t2_rxd", ev_data[1], {64'h0, 64'h1_0000_0005});
            chk("t2_txd2", ev_data[2], {4'h0, 84'h123456789, 40'hFF_0000_0001});
        end
        chk("t2_pass", sts_pass, 32'd1);

        // backpressure: 10 stalled cycles
        ev_kind.delete(); ev_data.delete();
        w_c = txw(2'b00, 84'hC0FFEE, 40'h12_3456_789A);
        mem[0] = w_c;
        cfg_length = 10'd1; cfg_repeats = 32'd1; tx_tready = 1'b0; run = 1'b1;
        tick(); tick(); tick();
        run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("t3_hold_v", tx_tvalid, 1'b1);
            chk("t3_hold_d", tx_tdata, {4'h0, 84'hC0FFEE, 40'h12_3456_789A});
            chk("t3_hold_a", bram_porta_addr, 10'd0);
            tick();
        end
        chk("t3_noxfer", ev_kind.size(), 0);
        tx_tready = 1'b1;
        tick();
        chk("t3_after_v", tx_tvalid, 1'b0);
        chk("t3_one_beat", ev_kind.size(), 1);
        wait_idle(10, "t3_idle");
        chk("t3_pass", sts_pass, 32'd1);

        // repeats with HALT at mem[2]: 10 cycles per pass, last pass ends at cycle 30
        ev_kind.delete(); ev_data.delete();
        mem[0] = w_a; mem[1] = w_rx; mem[2] = HALT;
        cfg_length = 10'd5; cfg_repeats = 32'd3; run = 1'b1;
        for (int i = 0; i < 29; i++) tick();
        run = 1'b0;
        tick(); tick();
        chk("t4_c31_busy", busy, 1'b0);
        chk("t4_pass", sts_pass, 32'd3);
        chk("t4_nbeats", ev_kind.size(), 6);
        if (ev_kind.size() == 6) begin
            chk("t4_k4", ev_kind[4], 0);
            chk("t4_k5", ev_kind[5], 1);
        end

        // stop request while a beat is stalled
        ev_kind.delete(); ev_data.delete();
        w_f = txw(2'b00, 84'hF00D, 40'd7);
        mem[0] = w_f; mem[1] = w_b;
        cfg_length = 10'd2; cfg_repeats = 32'd0; tx_tready = 1'b0; run = 1'b1;
        tick(); tick(); tick();
        chk("t5_v", tx_tvalid, 1'b1);
        run = 1'b0;
        tick(); tick(); tick();
        chk("t5_held_v", tx_tvalid, 1'b1);
        chk("t5_held_busy", busy, 1'b1);
        tx_tready = 1'b1;
        tick();
        chk("t5_next_v", tx_tvalid, 1'b0);
        tick();
        chk("t5_stop_busy", busy, 1'b0);
        chk("t5_stop_pass", sts_pass, 32'd0);
        chk("t5_one_beat", ev_kind.size(), 1);

        // restart from addr 0 with repeat-forever, one word per pass
        cfg_length = 10'd1; run = 1'b1;
        tick();
        chk("t5_rs_addr", bram_porta_addr, 10'd0);
        chk("t5_rs_pass", sts_pass, 32'd0);
        tick(); tick();
        chk("t5_rs_d", tx_tdata, {4'h0, 84'hF00D, 40'd7});
        tick(); tick(); tick(); tick();
        chk("t5_rs_v2", tx_tvalid, 1'b1);
        chk("t5_rs_pass1", sts_pass, 32'd1);
        tx_tready = 1'b0;

        // async reset between edges while in SEND
        #2 aresetn = 1'b0;
        #1;
        chk("t6_txv", tx_tvalid, 1'b0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_pass", sts_pass, 32'd0);
        chk("t6_txd", tx_tdata, 128'd0);
        run = 1'b1; cfg_length = 10'd0;
        tick();
        aresetn = 1'b1;
        tick(); tick(); tick();
        chk("t6_len0_busy", busy, 1'b0);
        chk("t6_len0_txv", tx_tvalid, 1'b0);
        chk("never_both", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
